// File: rtl/pipe_scroller.sv
// pipe_scroller
// Multi-column pipe scroller for the LED-matrix game. It holds COLS columns
// of ROWS-bit pipe pixels and shifts them one column toward the bird every
// period+1 clocks. New columns are pulled from the pipe generator with the
// take strobe. It also detects bird/pipe collisions at BIRD_COL, counts the
// pipes passed, and freezes the display on a collision or an external game over.
//
// Ports:
//   clk        clock
//   reset      synchronous, active-high reset
//   ongoing    game running; low clears the block back to IDLE
//   game_over  external freeze request (level)
//   period     scroll interval minus one, sampled every cycle
//   next_col   column that enters at index COLS-1 on a shift
//   bird_row   one-hot bird row
//   take       high in the cycle next_col is consumed
//   frame      frame[c*ROWS +: ROWS] = column c (column 0 exits next)
//   hit        sticky collision flag
//   frozen     high while the display is frozen
//   score      pipes passed, saturating
module pipe_scroller #(
    parameter int ROWS     = 8,
    parameter int COLS     = 16,
    parameter int DIV_W    = 8,
    parameter int BIRD_COL = 2,
    parameter int SCORE_W  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ongoing,
    input  logic                 game_over,
    input  logic [DIV_W-1:0]     period,
    input  logic [ROWS-1:0]      next_col,
    input  logic [ROWS-1:0]      bird_row,
    output logic                 take,
    output logic [COLS*ROWS-1:0] frame,
    output logic                 hit,
    output logic                 frozen,
    output logic [SCORE_W-1:0]   score
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FROZEN
    } state_t;

    state_t            state;
    logic [ROWS-1:0]   cols [COLS];
    logic [DIV_W-1:0]  div;

    logic collide;
    logic freeze;
    logic div_due;
    logic pipe_passed;

    // Collision is judged on the registered column, never on next_col.
    assign collide = |(cols[BIRD_COL] & bird_row);
    assign freeze  = collide | game_over;
    assign div_due = (div == period);

    // A pipe counts once, when its trailing column leaves the bird column.
    assign pipe_passed = (cols[BIRD_COL] != '0) && (cols[BIRD_COL+1] == '0);

    // take mirrors the shift enable exactly. It is gated by reset and ongoing
    // so it never pulses on a cycle where the column would not be consumed.
    assign take = ongoing & ~reset & (state == RUN) & div_due & ~freeze;

    genvar g;
    generate
        for (g = 0; g < COLS; g++) begin : g_frame
            assign frame[g*ROWS +: ROWS] = cols[g];
        end
    endgenerate

    // In RUN, freezing wins over a due shift, so a pipe that collides while
    // sitting on the bird column is never shifted out and never scored.
    // A period lowered below the current div makes div count on through
    // the 2^DIV_W wrap.
    always_ff @(posedge clk) begin
        if (reset || !ongoing) begin
            state  <= IDLE;
            div    <= '0;
            hit    <= 1'b0;
            frozen <= 1'b0;
            score  <= '0;
            for (int c = 0; c < COLS; c++) begin
                cols[c] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    state <= RUN;
                end
                RUN: begin
                    if (freeze) begin
                        state  <= FROZEN;
                        frozen <= 1'b1;
                        if (collide) begin
                            hit <= 1'b1;
                        end
                    end else if (div_due) begin
                        for (int c = 0; c < COLS - 1; c++) begin
                            cols[c] <= cols[c+1];
                        end
                        cols[COLS-1] <= next_col;
                        div          <= '0;
                        if (pipe_passed && (score != '1)) begin
                            score <= score + SCORE_W'(1);
                        end
                    end else begin
                        div <= div + DIV_W'(1);
                    end
                end
                FROZEN: begin
                    state <= FROZEN;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_scroller.sv
// tb_pipe_scroller
// Scoreboard bench for pipe_scroller. Each stimulus cycle predicts the DUT
// outputs from a queue-based behavioural model and pushes them onto a
// scoreboard queue. A monitor pops one entry per cycle and compares it with
// the DUT outputs on the falling edge.
module tb_pipe_scroller;

    localparam int ROWS     = 8;
    localparam int COLS     = 16;
    localparam int DIV_W    = 8;
    localparam int BIRD_COL = 2;
    localparam int SCORE_W  = 2;

    localparam int M_IDLE   = 0;
    localparam int M_RUN    = 1;
    localparam int M_FROZEN = 2;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 ongoing = 1'b0;
    logic                 game_over = 1'b0;
    logic [DIV_W-1:0]     period = '0;
    logic [ROWS-1:0]      next_col = '0;
    logic [ROWS-1:0]      bird_row = '0;
    logic                 take;
    logic [COLS*ROWS-1:0] frame;
    logic                 hit;
    logic                 frozen;
    logic [SCORE_W-1:0]   score;

    always #5 clk = ~clk;

    pipe_scroller #(
        .ROWS(ROWS), .COLS(COLS), .DIV_W(DIV_W),
        .BIRD_COL(BIRD_COL), .SCORE_W(SCORE_W)
    ) dut (
        .clk(clk), .reset(reset), .ongoing(ongoing), .game_over(game_over),
        .period(period), .next_col(next_col), .bird_row(bird_row),
        .take(take), .frame(frame), .hit(hit), .frozen(frozen), .score(score)
    );

    typedef struct {
        logic                 take;
        logic [COLS*ROWS-1:0] frame;
        logic                 hit;
        logic                 frozen;
        logic [SCORE_W-1:0]   score;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    // Behavioural model: the display is a queue of columns, index 0 first out.
    logic [ROWS-1:0] mq[$];
    int              mdiv;
    int              mscore;
    bit              mhit;
    int              mmode;

    function automatic void modelClear();
        mq.delete();
        for (int i = 0; i < COLS; i++) mq.push_back('0);
        mdiv   = 0;
        mscore = 0;
        mhit   = 1'b0;
        mmode  = M_IDLE;
    endfunction

    // Drives one cycle of inputs, predicts this cycle's outputs, then
    // advances the model across the coming clock edge.
    task automatic applyStimulus(input bit r, input bit on, input bit go,
                                 input int per, input logic [ROWS-1:0] nc,
                                 input logic [ROWS-1:0] br);
        exp_t e;
        bit   collide;
        bit   due;
        @(posedge clk);
        #1;
        reset     = r;
        ongoing   = on;
        game_over = go;
        period    = DIV_W'(per);
        next_col  = nc;
        bird_row  = br;
        collide = ((mq[BIRD_COL] & br) != '0);
        due = !r && on && (mmode == M_RUN) && !collide && !go && (mdiv == per);
        e.take = due;
        for (int c = 0; c < COLS; c++) e.frame[c*ROWS +: ROWS] = mq[c];
        e.hit    = mhit;
        e.frozen = (mmode == M_FROZEN);
        e.score  = SCORE_W'(mscore);
        sb.push_back(e);
        if (r || !on) begin
            modelClear();
        end else if (mmode == M_IDLE) begin
            mmode = M_RUN;
        end else if (mmode == M_RUN) begin
            if (collide || go) begin
                mmode = M_FROZEN;
                if (collide) mhit = 1'b1;
            end else if (due) begin
                if (mq[BIRD_COL] != '0 && mq[BIRD_COL+1] == '0 &&
                    mscore < (1 << SCORE_W) - 1) mscore++;
                void'(mq.pop_front());
                mq.push_back(nc);
                mdiv = 0;
            end else begin
                mdiv = (mdiv + 1) % (1 << DIV_W);
            end
        end
    endtask

    task automatic runCycles(input int n, input bit on, input bit go,
                             input int per, input logic [ROWS-1:0] nc,
                             input logic [ROWS-1:0] br);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, on, go, per, nc, br);
    endtask

    task automatic checkOutput(input exp_t e);
        total++;
        if (take !== e.take) begin
            bad++;
            $display("[TB] FAIL take: got %b expected %b at %0t", take, e.take, $time);
        end
        total++;
        if (frame !== e.frame) begin
            bad++;
            $display("[TB] FAIL frame: got %h expected %h at %0t", frame, e.frame, $time);
        end
        total++;
        if (hit !== e.hit) begin
            bad++;
            $display("[TB] FAIL hit: got %b expected %b at %0t", hit, e.hit, $time);
        end
        total++;
        if (frozen !== e.frozen) begin
            bad++;
            $display("[TB] FAIL frozen: got %b expected %b at %0t", frozen, e.frozen, $time);
        end
        total++;
        if (score !== e.score) begin
            bad++;
            $display("[TB] FAIL score: got %0d expected %0d at %0t", score, e.score, $time);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() != 0) checkOutput(sb.pop_front());
    end

    initial begin
        int per;
        modelClear();

        // Reset, then idle with ongoing low.
        $display("[TB] reset and idle");
        applyStimulus(1'b1, 1'b0, 1'b0, 0, '0, 8'h01);
        applyStimulus(1'b1, 1'b0, 1'b0, 0, '0, 8'h01);
        runCycles(5, 1'b0, 1'b0, 0, '0, 8'h01);

        // Period 3: take every fourth cycle, 0xC3 enters at the top column.
        $display("[TB] period 3 scroll");
        runCycles(14, 1'b1, 1'b0, 3, 8'hC3, 8'h01);
        runCycles(1, 1'b0, 1'b0, 3, '0, 8'h01);

        // Full scroll of a single 0x80 column at period 0.
        $display("[TB] full scroll");
        runCycles(2, 1'b1, 1'b0, 0, 8'h80, 8'h01);
        runCycles(20, 1'b1, 1'b0, 0, 8'h00, 8'h01);
        runCycles(1, 1'b0, 1'b0, 0, '0, 8'h01);

        // Collision of 0xF0 with bird row 0x10, then a held frame.
        $display("[TB] collision");
        runCycles(2, 1'b1, 1'b0, 0, 8'hF0, 8'h10);
        runCycles(26, 1'b1, 1'b0, 0, 8'h00, 8'h10);
        runCycles(1, 1'b0, 1'b0, 0, '0, 8'h10);

        // External game over with no overlap; next_col changes are ignored.
        $display("[TB] game over");
        for (int i = 0; i < 12; i++)
            applyStimulus(1'b0, 1'b1, 1'b0, 1, ROWS'($urandom) & 8'hFE, 8'h01);
        runCycles(8, 1'b1, 1'b1, 1, 8'hD5, 8'h01);
        runCycles(4, 1'b1, 1'b0, 1, 8'hD5, 8'h01);
        runCycles(1, 1'b0, 1'b0, 1, '0, 8'h01);
        runCycles(8, 1'b1, 1'b0, 1, 8'h40, 8'h01);
        runCycles(1, 1'b0, 1'b0, 0, '0, 8'h01);

        // Five separated pipes drive the 2-bit score into saturation.
        $display("[TB] score saturation");
        runCycles(1, 1'b1, 1'b0, 0, '0, 8'h01);
        for (int p = 0; p < 5; p++) begin
            runCycles(1, 1'b1, 1'b0, 0, 8'h80, 8'h01);
            runCycles(3, 1'b1, 1'b0, 0, 8'h00, 8'h01);
        end
        runCycles(20, 1'b1, 1'b0, 0, 8'h00, 8'h01);
        runCycles(1, 1'b0, 1'b0, 0, '0, 8'h01);

        // Period lowered below the running divider: the divider wraps.
        $display("[TB] divider wrap");
        for (int i = 0; i < 9; i++)
            applyStimulus(1'b0, 1'b1, 1'b0, 10, ROWS'($urandom) & 8'hFE, 8'h01);
        for (int i = 0; i < 270; i++)
            applyStimulus(1'b0, 1'b1, 1'b0, 3, ROWS'($urandom) & 8'hFE, 8'h01);

        // Reset landing on a cycle where a shift is due.
        $display("[TB] mid-operation reset");
        for (int i = 0; i < 60; i++) begin
            if (mmode == M_RUN && mdiv == 2 && mq[COLS-1] != '0) break;
            applyStimulus(1'b0, 1'b1, 1'b0, 2, ROWS'($urandom) | 8'h01, 8'h00);
        end
        applyStimulus(1'b1, 1'b1, 1'b0, 2, 8'hAA, 8'h00);
        runCycles(6, 1'b1, 1'b0, 2, 8'h11, 8'h00);

        // Randomized play.
        $display("[TB] random play");
        per = 1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 63) == 0)
                per = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 40) : $urandom_range(0, 5);
            applyStimulus($urandom_range(0, 499) == 0,
                          $urandom_range(0, 59) != 0,
                          $urandom_range(0, 199) == 0,
                          per,
                          ROWS'($urandom & $urandom & $urandom),
                          ROWS'(1) << $urandom_range(0, ROWS - 1));
        end

        repeat (3) @(posedge clk);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("[TB] FAIL drain: got %0d pending entries expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_scroller.md
Name: pipe_scroller

Overview:
- Parametrised multi-column pipe scroller for the LED-matrix game. Holds COLS columns of ROWS-bit pipe pixels, shifts them one column toward the bird every PERIOD+1 clocks, and pulls new columns from the pipe generator via a take strobe.
- Also checks for a bird/pipe collision at a fixed bird column, counts pipes passed (score), and freezes the display on collision or external game over.
- Sits between the pipe generator and the matrix driver.

Parameters:
- ROWS, 8, pixel rows per column (width of next_col and bird_row).
- COLS, 16, number of columns held (scroll depth).
- DIV_W, 8, width of the period input and internal divider.
- BIRD_COL, 2, column index checked for collision; legal range 0 ≤ BIRD_COL ≤ COLS-2.
- SCORE_W, 8, score counter width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- ongoing  in  1  game running; low returns block to IDLE and clears it.
- game_over  in  1  external freeze request (level).
- period  in  DIV_W  scroll interval minus one; sampled every cycle.
- next_col  in  ROWS  column that enters at index COLS-1 on a shift.
- bird_row  in  ROWS  one-hot bird position.
- take  out  1  one-cycle pulse; asserted in the cycle next_col is consumed.
- frame  out  COLS*ROWS  frame[c*ROWS +: ROWS] = column c; column 0 exits, column COLS-1 enters.
- hit  out  1  sticky collision flag.
- frozen  out  1  high while in FROZEN.
- score  out  SCORE_W  pipes passed, saturating.

Behaviour:
- Reset and all outputs after reset: frame=0, hit=0, score=0, take=0, frozen=0, divider=0, state=IDLE.
- Priority: reset > ~ongoing > everything else. ~ongoing in any state gives the same clear as reset on the next edge.
- States:
  - IDLE: everything held cleared. Goes to RUN on the first edge with ongoing=1.
  - RUN:
    - Divider counts 0..period.
    - When div == period and no freeze condition, a shift occurs at that edge: col[c] <= col[c+1] for c < COLS-1; col[COLS-1] <= next_col; col[0] content is discarded; div <= 0.
    - Otherwise div <= div+1.
    - period=0 means a shift every cycle. The first shift occurs period+1 cycles after entering RUN.
    - If period is lowered below the current div, div continues to count up and wraps through 2^DIV_W. No special handling.
  - FROZEN: frame, div, and score are held. take=0, frozen=1. Exits only via ~ongoing or reset, to IDLE.
- take: combinational, equal to the shift-enable (RUN & div==period & ~freeze).
- Collision: collide = |(col[BIRD_COL] & bird_row), evaluated on the registered frame.
- Freeze condition in RUN is collide | game_over.
  - When true, the shift in that cycle is suppressed (take=0), and the state goes to FROZEN at the edge.
  - hit <= 1 only if collide (game_over alone leaves hit=0).
  - Simultaneous collide and due shift: no shift, no score.
- Score: on a shift, if col[BIRD_COL] != 0 and col[BIRD_COL+1] == 0 (trailing edge of a pipe passing the bird), score increments by 1, saturating at 2^SCORE_W-1.
- No combinational path from next_col to frame. Latency from a shift edge to frame update is 0 cycles after that edge (registered).

Test Plan:
- Reset/idle:
  - reset=1 two cycles, then ongoing=0 for 5 cycles → frame=0, take never asserted, score=0, hit=0.
  - Then ongoing=1, period=3 → take pulses at cycles 4, 8, 12 after entry. With next_col=8'hC3, after the first shift frame[(COLS-1)*8 +: 8]=8'hC3 and all other columns are 0.
- Full scroll, period=0, bird_row=8'h01:
  - Feed 8'h80 once, then zeros → the column appears at index COLS-1 down to 0 over successive cycles, then drops out. No hit, since bit 0 is never set.
  - score=1 on the shift where it leaves index BIRD_COL.
- Collision, period=0, bird_row=8'h10:
  - Feed 8'hF0 → in the cycle it sits at BIRD_COL: take=0, hit=1 and frozen=1 at the next edge.
  - Frame unchanged for the following 10 cycles; score not incremented for that pipe.
- External game_over:
  - Assert game_over during RUN with no overlap → frozen=1, hit=0, frame held.
  - Changing next_col to 8'hD5 has no effect.
  - ongoing=0 then 1 → frame=0, score=0, scrolling resumes.
- Score saturation with SCORE_W=2: pass 5 separated pipes → score goes 1, 2, 3, 3, 3.
- Mid-operation reset: assert reset on a cycle where take would fire (div==period) → no shift, frame=0 and div=0 next cycle.
